weight_mult_engine: RTL
=======================

# weight_mult_engine

Parametrised, sequential successor to the flat combinational weight-multiplier array. Accepts one channel word per valid/ready handshake. Each word is split into `N_LANE` unsigned lanes. For every lane it forms two products with an iterative shift-add datapath: the self-weighted product and the f-weighted product. The self-weighted product multiplies the lane by its own top `COEF_W` bits. The f-weighted product multiplies the lane by the top `COEF_W` bits of a frame-latched `fsum`. It sits between the g/f summation stage and the distance accumulator, and trades area for `COEF_W+1` cycles per channel.

## Interface
- `N_CH`, 16, channels per frame; sets the channel-index counter range.
- `N_LANE`, 4, lanes per channel word.
- `IN_W`, 11, lane width and `fsum` width.
- `COEF_W`, 3, coefficient width; must satisfy 1 ≤ `COEF_W` ≤ `IN_W`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort; returns the block to IDLE and resets the channel index.
- `in_valid`  in  1  channel word valid.
- `in_ready`  out  1  block can accept a word.
- `in_gsum`  in  `N_LANE*IN_W`  channel word; lane k = bits `[k*IN_W +: IN_W]`.
- `in_fsum`  in  `IN_W`  f sum; sampled only on channel 0 of a frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_wg`  out  `N_LANE*PROD_W`  self-weighted products; lane k = bits `[k*PROD_W +: PROD_W]`.
- `out_wfg`  out  `N_LANE*PROD_W`  f-weighted products, same packing as `out_wg`.
- `out_ch`  out  `$clog2(N_CH)`  index of the channel being presented.
- `out_last`  out  1  high when `out_ch == N_CH-1`.

## Operation
- `PROD_W = IN_W + COEF_W`. Products are unsigned and exact; the maximum value (2^IN_W−1)(2^COEF_W−1) always fits, so there is no saturation.
- Coefficient selection:
  - Self coefficient for lane k: `lane_k[IN_W-1 -: COEF_W]`.
  - f coefficient: `fsum_q[IN_W-1 -: COEF_W]`.
- `fsum_q` loads from `in_fsum` on an accepted word when the channel index is 0. It is held for the rest of the frame.
- Channel index increments on each accepted word and wraps from `N_CH-1` to 0.
- FSM:
  - IDLE: `in_ready=1`. On accept: latch the lanes and both coefficients, clear the accumulators and the bit counter, go to MUL.
  - MUL: one coefficient bit per cycle, LSB first. For bit i, add `lane << i` to each accumulator when that coefficient's bit i is 1. After bit `COEF_W-1`, go to OUT.
  - OUT: `out_valid=1`; outputs are stable until the handshake. On `out_ready`: if `in_valid`, accept the new word and go directly to MUL; otherwise go to IDLE.
- `in_ready = (state==IDLE) | (state==OUT & out_ready)`, forced to 0 while `clr` is high.
- `clr` has priority over every other event. It discards any in-flight result, sets `out_valid=0` and channel index 0, and does not load `fsum_q`.
- A zero coefficient still takes the full `COEF_W` MUL cycles, so latency is fixed.

## Timing
- Reset values: state IDLE, `in_ready=1` (only after reset deasserts), `out_valid=0`, `out_wg=0`, `out_wfg=0`, `out_ch=0`, `out_last=0`, `fsum_q=0`, channel index 0.
- Latency: a word accepted at edge E0 gives `out_valid` high after edge E0+`COEF_W`.
- Throughput: one channel per `COEF_W+1` cycles when `out_ready` is held high (OUT→MUL back-to-back).
- Back-pressure: `out_ready=0` holds OUT indefinitely with all outputs unchanged. `in_ready` stays 0 during that time.
- `rst_n` asserted mid-MUL or mid-OUT clears everything immediately and asynchronously. The partial result is lost.

## Structure
- Package `weight_mult_pkg`:
  - state enum `{IDLE, MUL, OUT}`;
  - function `prod_w(in_w, coef_w)`;
  - lane pack/unpack helper functions.
- Sub-module `lane_shift_add`, instantiated `N_LANE` times:
  - holds one lane register, two coefficient registers and two `PROD_W` accumulators;
  - inputs: load, step and bit index from the top-level FSM.
- The top level owns the FSM, bit counter, channel counter, `fsum_q` and the handshakes.

## Test plan
- Single word with defaults: lane0=`11'h7FF`, `in_fsum=11'h500` on channel 0 → `out_wg` lane0 = 14329 (`14'h37F9`), `out_wfg` lane0 = 10235; `out_valid` rises 3 cycles after accept.
- Lane = `11'h300`, `fsum=11'h500` → wg = 2304 (`14'h900`), wfg = 3840 (`14'hF00`). Lane = `11'h0FF` → wg = 0, latency still 3.
- Stream of 16 words with `out_ready=1`:
  - one result every 4 cycles;
  - `out_ch` 0..15, `out_last` only on 15;
  - the 17th word wraps to `out_ch=0` and re-samples `fsum`; a changed `in_fsum` on channels 1..15 is ignored.
- Hold `out_ready=0` for 10 cycles in OUT → outputs stable and `in_ready=0`; release with `in_valid=1` → the next word is accepted the same cycle.
- `clr` during MUL of channel 5 → no `out_valid`, next accepted word reports `out_ch=0`. `clr` together with `in_valid` → word not accepted.
- Async `rst_n` pulse mid-MUL (not on a clock edge) → all outputs 0 immediately; a normal transaction afterwards produces correct products.

Source files
------------

// File: rtl/weight_mult_pkg.sv
// weight_mult_pkg: shared FSM type, product-width rule and lane pack/unpack helpers
package weight_mult_pkg;
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  typedef logic [255:0] bus_t;
  function automatic int prod_w(input int in_w, input int coef_w);
    return in_w + coef_w;
  endfunction
  function automatic logic [63:0] unpack_lane(input bus_t word, input int k, input int w);
    return 64'(word >> (k * w)) & ((64'd1 << w) - 64'd1);
  endfunction
  function automatic bus_t pack_lane(input bus_t word, input int k, input int w, input logic [63:0] val);
    bus_t m;
    m = bus_t'((64'd1 << w) - 64'd1) << (k * w);
    return (word & ~m) | ((bus_t'(val) << (k * w)) & m);
  endfunction
endpackage

// File: rtl/weight_mult_engine_lane_shift_add.sv
// lane_shift_add: one lane's shift-add multiplier, self- and f-weighted products in parallel
module lane_shift_add
  import weight_mult_pkg::*;
#(
  parameter int IN_W = 11,
  parameter int COEF_W = 3,
  parameter int PROD_W = 14,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [CNT_W-1:0]  bit_idx,
  input  logic [IN_W-1:0]   lane_in,
  input  logic [COEF_W-1:0] fcoef_in,
  output logic [PROD_W-1:0] wg,
  output logic [PROD_W-1:0] wfg
);
  logic [IN_W-1:0] lane_q;
  logic [COEF_W-1:0] scoef_q, fcoef_q;
  logic [PROD_W-1:0] addend;
  assign addend = PROD_W'(lane_q) << bit_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane_q <= '0;
      scoef_q <= '0;
      fcoef_q <= '0;
      wg <= '0;
      wfg <= '0;
    end else if (load) begin
      lane_q <= lane_in;
      scoef_q <= lane_in[IN_W-1 -: COEF_W];
      fcoef_q <= fcoef_in;
      wg <= '0;
      wfg <= '0;
    end else if (step) begin
      if (scoef_q[bit_idx]) wg <= wg + addend;
      if (fcoef_q[bit_idx]) wfg <= wfg + addend;
    end
endmodule

// File: rtl/weight_mult_engine.sv
// weight_mult_engine: sequential per-lane weight multiplier with valid/ready handshakes
module weight_mult_engine
  import weight_mult_pkg::*;
#(
  parameter int N_CH = 16,
  parameter int N_LANE = 4,
  parameter int IN_W = 11,
  parameter int COEF_W = 3,
  localparam int PROD_W = prod_w(IN_W, COEF_W),
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANE*IN_W-1:0]   in_gsum,
  input  logic [IN_W-1:0]          in_fsum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANE*PROD_W-1:0] out_wg,
  output logic [N_LANE*PROD_W-1:0] out_wfg,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last
);
  localparam int CNT_W = COEF_W > 1 ? $clog2(COEF_W) : 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] bit_q;
  logic [CH_W-1:0] ch_q, out_ch_q;
  logic [IN_W-1:0] fsum_q;
  logic [COEF_W-1:0] fcoef;
  logic accept, last_bit, step;
  logic [PROD_W-1:0] wg_a [N_LANE];
  logic [PROD_W-1:0] wfg_a [N_LANE];
  bus_t wg_bus, wfg_bus;
  assign in_ready = ~clr & ((state_q == IDLE) | ((state_q == OUT) & out_ready));
  assign out_valid = ~clr & (state_q == OUT);
  assign accept = in_valid & in_ready;
  assign step = state_q == MUL;
  assign last_bit = bit_q == CNT_W'(COEF_W - 1);
  // channel 0 multiplies by the fsum arriving with it, not the stale frame value
  assign fcoef = (ch_q == '0) ? in_fsum[IN_W-1 -: COEF_W] : fsum_q[IN_W-1 -: COEF_W];
  assign out_ch = out_ch_q;
  assign out_last = out_ch_q == CH_W'(N_CH - 1);
  always_comb begin
    state_d = clr ? IDLE
            : accept ? MUL
            : (step & last_bit) ? OUT
            : ((state_q == OUT) & out_ready) ? IDLE
            : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q <= '0;
      ch_q <= '0;
      out_ch_q <= '0;
      fsum_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= step ? bit_q + 1'b1 : '0;
      if (clr) begin
        ch_q <= '0;
        out_ch_q <= '0;
      end else if (accept) begin
        ch_q <= (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        out_ch_q <= ch_q;
        if (ch_q == '0) fsum_q <= in_fsum;
      end
    end
  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    lane_shift_add #(.IN_W(IN_W), .COEF_W(COEF_W), .PROD_W(PROD_W), .CNT_W(CNT_W)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .load(accept),
      .step(step),
      .bit_idx(bit_q),
      .lane_in(IN_W'(unpack_lane(bus_t'(in_gsum), k, IN_W))),
      .fcoef_in(fcoef),
      .wg(wg_a[k]),
      .wfg(wfg_a[k])
    );
  end
  always_comb begin
    wg_bus = '0;
    wfg_bus = '0;
    for (int i = 0; i < N_LANE; i++) begin
      wg_bus = pack_lane(wg_bus, i, PROD_W, 64'(wg_a[i]));
      wfg_bus = pack_lane(wfg_bus, i, PROD_W, 64'(wfg_a[i]));
    end
  end
  assign out_wg = (N_LANE*PROD_W)'(wg_bus);
  assign out_wfg = (N_LANE*PROD_W)'(wfg_bus);
endmodule
